// File: rtl/program_loader.sv
// Byte-serial program loader: assembles big-endian byte pairs into a small
// 16-bit instruction store, hiding the store from the CPU while a load runs.
`timescale 1ns/1ps

module program_loader #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic [ADDR_W-1:0] address,
   output logic [15:0]       instruction,
   output logic              loading,
   output logic              done
);

   localparam int                DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      HI,
      LO,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] wr_ptr;
   logic [7:0]        hi_byte;
   logic [15:0]       mem [DEPTH];
   logic              xfer;

   assign xfer = byte_valid & byte_ready;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_next = state;
      byte_ready = 1'b0;
      loading    = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (load_start) state_next = HI;
         end
         HI: begin
            byte_ready = 1'b1;
            loading    = 1'b1;
            if (xfer) state_next = LO;
         end
         LO: begin
            byte_ready = 1'b1;
            loading    = 1'b1;
            if (xfer) state_next = (wr_ptr == LAST) ? DONE : HI;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         hi_byte <= '0;
         // NOTE: the store is reset word by word because a reset must leave
         // no stale program visible to the CPU; it therefore maps to flops.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && load_start) wr_ptr <= '0;
         if (xfer && state == HI) hi_byte <= byte_data;
         if (xfer && state == LO) begin
            mem[wr_ptr] <= {hi_byte, byte_data};
            if (wr_ptr != LAST) wr_ptr <= wr_ptr + 1'b1;
         end
      end
   end

   // Masked during a load so the CPU never fetches a half-written program.
   assign instruction = loading ? 16'h0000 : mem[address];

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL provide parameter ADDR_W, default 3, word-address width; depth = 2**ADDR_W words of 16 bits (8 by default).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port load_start  input  1  single-cycle request to begin a full program load.
REQ-005 SHALL have port byte_valid  input  1  source asserts when byte_data holds a byte.
REQ-006 SHALL have port byte_data  input  8  program byte; first byte of each word is bits [15:8], second is bits [7:0].
REQ-007 SHALL have port byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 SHALL have port address  input  ADDR_W  CPU instruction-fetch word address.
REQ-009 SHALL have port instruction  output  16  CPU fetch data, combinational from address.
REQ-010 SHALL have port loading  output  1  high while a load is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the final word has been written.

Function
REQ-012 SHALL contain a 2**ADDR_W x 16 storage array written only by the load FSM.
REQ-013 SHALL implement FSM states IDLE, HI, LO, DONE.
REQ-014 In IDLE with load_start=1, the FSM SHALL go to HI on the next edge and clear the write pointer wr_ptr to 0.
REQ-015 SHALL transfer a byte only on an edge where byte_valid=1 and byte_ready=1; byte_valid without byte_ready SHALL have no effect.
REQ-016 SHALL drive byte_ready=1 exactly in states HI and LO, and 0 in IDLE and DONE.
REQ-017 In HI, an accepted byte SHALL be latched as the high byte and the FSM SHALL move to LO.
REQ-018 In LO, an accepted byte SHALL write {high byte, byte_data} into mem[wr_ptr] on that same edge.
REQ-019 On that same edge, if wr_ptr is the last index, the FSM SHALL go to DONE; otherwise wr_ptr SHALL increment and the FSM SHALL go to HI.
REQ-020 DONE SHALL last exactly one cycle with done=1, then the FSM SHALL return to IDLE; done SHALL be 0 in all other states.
REQ-021 SHALL drive loading=1 in HI and LO, and 0 in IDLE and DONE.
REQ-022 With back-to-back valid bytes, a full default load SHALL take 16 accepting cycles, with done asserted in the 17th cycle after the first transfer edge.
REQ-023 SHALL ignore load_start in HI, LO and DONE; it neither restarts nor resets wr_ptr.
REQ-024 SHALL drive instruction = mem[address] when loading=0 and 16'h0000 when loading=1, so the CPU fetches no partial program.
REQ-025 SHALL make a written word visible on instruction from the cycle after its write edge, once loading=0.
REQ-026 SHALL leave words not yet rewritten in an interrupted load unchanged (subject to REQ-027).

Reset
REQ-027 While rst=1 at an edge, the block SHALL enter IDLE, clear wr_ptr, clear the high-byte latch and clear all memory words to 16'h0000.
REQ-028 After reset, the block SHALL drive byte_ready=0, loading=0, done=0 and instruction=16'h0000 for every address.
REQ-029 Reset SHALL take priority over load_start and byte transfers on the same edge.
REQ-030 Reset asserted mid-load SHALL abort the load with no done pulse.

Verification
REQ-031 Bench SHALL cover full load: load_start, then 16 back-to-back bytes 1C 0A, 14 20, 32 80, FC 00 x5 -> done for one cycle 17 cycles after the first transfer; address 0..7 reads 1C0A, 1420, 3280, FC00 x5.
REQ-032 Bench SHALL cover backpressure and gaps: byte_valid toggled 1,0,0,1 pattern -> only valid&ready edges counted; memory contents identical to REQ-031.
REQ-033 Bench SHALL cover readback masking: address=0 during load -> instruction=0000 while loading=1; after done, instruction=1C0A.
REQ-034 Bench SHALL cover ignored restart: load_start pulsed after word 2 is written -> load continues, word 3 lands at address 3, done still after 8 words.
REQ-035 Bench SHALL cover reset mid-load: rst after 3 words -> next cycle byte_ready=0, loading=0, all addresses read 0000, no done pulse.
REQ-036 Bench SHALL cover idle bytes: byte_valid=1 with byte_data=AA in IDLE -> byte_ready=0, memory unchanged, a subsequent load behaves as in REQ-031.
